// File: rtl/lpif_tx_arbiter.sv
// rtl/lpif_tx_arbiter.sv - packet-granular TLP/DLLP arbiter driving the LPIF transmit port
//
// Purpose:
//   Shares one LPIF transmit port between a TLP source and a DLLP source.
//   DLLPs win arbitration unless a waiting TLP has been passed over STARVE_MAX
//   times in a row. A grant is held until the packet's last beat is accepted.
//   Accepted beats are registered into a single output stage (1-cycle latency,
//   1 beat/cycle). Loss of linkUp drops the beat in flight and aborts any burst.
//
// Ports:
//   CLK, lpreset (async active-low), linkUp
//   tlp_*  : TLP source stream (valid/ready/data/bvalid/start/end/last)
//   dllp_* : DLLP source stream (same shape)
//   lp_irdy/pl_trdy : output beat handshake
//   lp_data, lp_valid, lp_tlpstart/end, lp_dlpstart/end : output beat
//   pkt_aborted : 1-cycle pulse when a burst is cut short by linkUp loss
module lpif_tx_arbiter #(
  parameter int DATA_W     = 512,
  parameter int BYTES      = DATA_W / 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              lpreset,
  input  logic              linkUp,
  input  logic              tlp_valid,
  output logic              tlp_ready,
  input  logic [DATA_W-1:0] tlp_data,
  input  logic [BYTES-1:0]  tlp_bvalid,
  input  logic [BYTES-1:0]  tlp_start,
  input  logic [BYTES-1:0]  tlp_end,
  input  logic              tlp_last,
  input  logic              dllp_valid,
  output logic              dllp_ready,
  input  logic [DATA_W-1:0] dllp_data,
  input  logic [BYTES-1:0]  dllp_bvalid,
  input  logic [BYTES-1:0]  dllp_start,
  input  logic [BYTES-1:0]  dllp_end,
  input  logic              dllp_last,
  output logic              lp_irdy,
  input  logic              pl_trdy,
  output logic [DATA_W-1:0] lp_data,
  output logic [BYTES-1:0]  lp_valid,
  output logic [BYTES-1:0]  lp_tlpstart,
  output logic [BYTES-1:0]  lp_tlpend,
  output logic [BYTES-1:0]  lp_dlpstart,
  output logic [BYTES-1:0]  lp_dlpend,
  output logic              pkt_aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TLP  = 2'd1,
    S_DLLP = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_starve_cnt;
  logic              r_irdy;
  logic [DATA_W-1:0] r_data;
  logic [BYTES-1:0]  r_valid;
  logic [BYTES-1:0]  r_tlpstart;
  logic [BYTES-1:0]  r_tlpend;
  logic [BYTES-1:0]  r_dlpstart;
  logic [BYTES-1:0]  r_dlpend;
  logic              r_aborted;

  logic w_free;
  logic w_pick_dllp;
  logic w_pick_tlp;
  logic w_gnt_tlp;
  logic w_gnt_dllp;
  logic w_tlp_acc;
  logic w_dllp_acc;

  // Output stage can take a new beat when empty or being drained this cycle.
  assign w_free = !r_irdy | pl_trdy;

  // IDLE arbitration: DLLP first, unless a TLP has already waited out its quota.
  assign w_pick_dllp = dllp_valid & (!tlp_valid | (r_starve_cnt != STARVE_LIM));
  assign w_pick_tlp  = tlp_valid & !w_pick_dllp;

  // State register
  always_ff @(posedge CLK or negedge lpreset) begin
    if (!lpreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A single-beat packet is granted and finished in IDLE,
  // so only multi-beat packets enter a BURST state.
  always_comb begin
    w_state_nxt = r_state;
    if (!linkUp) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tlp_acc && !tlp_last) begin
            w_state_nxt = S_TLP;
          end else if (w_dllp_acc && !dllp_last) begin
            w_state_nxt = S_DLLP;
          end
        end
        S_TLP: begin
          if (w_tlp_acc && tlp_last) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_DLLP: begin
          if (w_dllp_acc && dllp_last) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: grant is the arbitration pick in IDLE, locked in a BURST.
  always_comb begin
    w_gnt_tlp  = 1'b0;
    w_gnt_dllp = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_tlp  = w_pick_tlp;
        w_gnt_dllp = w_pick_dllp;
      end
      S_TLP:   w_gnt_tlp  = 1'b1;
      S_DLLP:  w_gnt_dllp = 1'b1;
      default: begin
        w_gnt_tlp  = 1'b0;
        w_gnt_dllp = 1'b0;
      end
    endcase
  end

  // lpreset in the ready term keeps every output at 0 while reset is held.
  assign tlp_ready  = w_gnt_tlp  & w_free & linkUp & lpreset;
  assign dllp_ready = w_gnt_dllp & w_free & linkUp & lpreset;
  assign w_tlp_acc  = tlp_valid  & tlp_ready;
  assign w_dllp_acc = dllp_valid & dllp_ready;

  // Starvation counter: only packet grants made in IDLE count.
  always_ff @(posedge CLK or negedge lpreset) begin
    if (!lpreset) begin
      r_starve_cnt <= 4'd0;
    end else if (!linkUp) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_tlp_acc) begin
        r_starve_cnt <= 4'd0;
      end else if (w_dllp_acc && tlp_valid && (r_starve_cnt != STARVE_LIM)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  // Registered output stage
  always_ff @(posedge CLK or negedge lpreset) begin
    if (!lpreset) begin
      r_irdy     <= 1'b0;
      r_data     <= '0;
      r_valid    <= '0;
      r_tlpstart <= '0;
      r_tlpend   <= '0;
      r_dlpstart <= '0;
      r_dlpend   <= '0;
    end else if (!linkUp) begin
      r_irdy     <= 1'b0;
      r_data     <= '0;
      r_valid    <= '0;
      r_tlpstart <= '0;
      r_tlpend   <= '0;
      r_dlpstart <= '0;
      r_dlpend   <= '0;
    end else if (w_tlp_acc) begin
      r_irdy     <= 1'b1;
      r_data     <= tlp_data;
      r_valid    <= tlp_bvalid;
      r_tlpstart <= tlp_start;
      r_tlpend   <= tlp_end;
      r_dlpstart <= '0;
      r_dlpend   <= '0;
    end else if (w_dllp_acc) begin
      r_irdy     <= 1'b1;
      r_data     <= dllp_data;
      r_valid    <= dllp_bvalid;
      r_tlpstart <= '0;
      r_tlpend   <= '0;
      r_dlpstart <= dllp_start;
      r_dlpend   <= dllp_end;
    end else if (pl_trdy) begin
      r_irdy <= 1'b0;
    end
  end

  // Abort pulse: linkUp low while a multi-beat packet was open.
  always_ff @(posedge CLK or negedge lpreset) begin
    if (!lpreset) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= !linkUp && (r_state != S_IDLE);
    end
  end

  assign lp_irdy     = r_irdy;
  assign lp_data     = r_data;
  assign lp_valid    = r_valid;
  assign lp_tlpstart = r_tlpstart;
  assign lp_tlpend   = r_tlpend;
  assign lp_dlpstart = r_dlpstart;
  assign lp_dlpend   = r_dlpend;
  assign pkt_aborted = r_aborted;

endmodule

// File: tb/tb_lpif_tx_arbiter.sv
// tb/tb_lpif_tx_arbiter.sv - self-checking bench for lpif_tx_arbiter
module tb_lpif_tx_arbiter;

  localparam int DW = 32;
  localparam int BY = 4;

  logic          CLK = 1'b0;
  logic          lpreset;
  logic          linkUp;
  logic          tlp_valid, tlp_ready, tlp_last;
  logic [DW-1:0] tlp_data;
  logic [BY-1:0] tlp_bvalid, tlp_start, tlp_end;
  logic          dllp_valid, dllp_ready, dllp_last;
  logic [DW-1:0] dllp_data;
  logic [BY-1:0] dllp_bvalid, dllp_start, dllp_end;
  logic          lp_irdy, pl_trdy, pkt_aborted;
  logic [DW-1:0] lp_data;
  logic [BY-1:0] lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  lpif_tx_arbiter #(.DATA_W(DW), .BYTES(BY), .STARVE_MAX(4)) dut (
    .CLK(CLK), .lpreset(lpreset), .linkUp(linkUp),
    .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .tlp_data(tlp_data),
    .tlp_bvalid(tlp_bvalid), .tlp_start(tlp_start), .tlp_end(tlp_end), .tlp_last(tlp_last),
    .dllp_valid(dllp_valid), .dllp_ready(dllp_ready), .dllp_data(dllp_data),
    .dllp_bvalid(dllp_bvalid), .dllp_start(dllp_start), .dllp_end(dllp_end), .dllp_last(dllp_last),
    .lp_irdy(lp_irdy), .pl_trdy(pl_trdy), .lp_data(lp_data), .lp_valid(lp_valid),
    .lp_tlpstart(lp_tlpstart), .lp_tlpend(lp_tlpend),
    .lp_dlpstart(lp_dlpstart), .lp_dlpend(lp_dlpend), .pkt_aborted(pkt_aborted)
  );

  typedef struct {
    logic        lu, tv, tf, tl;
    logic [31:0] td;
    logic        dv, df, dl;
    logic [31:0] dd;
    logic        trdy;
    logic        e_tr, e_dr, e_irdy;
    logic [31:0] e_data;
    logic        e_tsrc, e_first, e_last, e_ab;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic lu, tv, tf, tl, input logic [31:0] td,
                     input logic dv, df, dl, input logic [31:0] dd, input logic trdy,
                     input logic e_tr, e_dr, e_irdy, input logic [31:0] e_data,
                     input logic e_tsrc, e_first, e_last, e_ab);
    vec_t v;
    v.lu = lu; v.tv = tv; v.tf = tf; v.tl = tl; v.td = td;
    v.dv = dv; v.df = df; v.dl = dl; v.dd = dd; v.trdy = trdy;
    v.e_tr = e_tr; v.e_dr = e_dr; v.e_irdy = e_irdy; v.e_data = e_data;
    v.e_tsrc = e_tsrc; v.e_first = e_first; v.e_last = e_last; v.e_ab = e_ab;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic lu, tv, tf, tl, input logic [31:0] td,
                       input logic dv, df, dl, input logic [31:0] dd, input logic trdy);
    linkUp      = lu;
    tlp_valid   = tv;
    tlp_data    = td;
    tlp_bvalid  = 4'hF;
    tlp_start   = tf ? 4'h1 : 4'h0;
    tlp_end     = tl ? 4'h8 : 4'h0;
    tlp_last    = tl;
    dllp_valid  = dv;
    dllp_data   = dd;
    dllp_bvalid = 4'h3;
    dllp_start  = df ? 4'h1 : 4'h0;
    dllp_end    = dl ? 4'h2 : 4'h0;
    dllp_last   = dl;
    pl_trdy     = trdy;
  endtask

  // Expected output beat; marks follow the bench's own encoding in drive().
  task automatic chk_beat(input string tag, input logic [31:0] data, input logic tsrc,
                          input logic first, input logic last);
    chk({tag, ".irdy"}, 32'(lp_irdy), 32'd1);
    chk({tag, ".data"}, lp_data, data);
    chk({tag, ".valid"}, 32'(lp_valid), tsrc ? 32'hF : 32'h3);
    chk({tag, ".tlpstart"}, 32'(lp_tlpstart), (tsrc && first) ? 32'h1 : 32'h0);
    chk({tag, ".tlpend"}, 32'(lp_tlpend), (tsrc && last) ? 32'h8 : 32'h0);
    chk({tag, ".dlpstart"}, 32'(lp_dlpstart), (!tsrc && first) ? 32'h1 : 32'h0);
    chk({tag, ".dlpend"}, 32'(lp_dlpend), (!tsrc && last) ? 32'h2 : 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".irdy"}, 32'(lp_irdy), 32'd0);
    chk({tag, ".data"}, lp_data, 32'd0);
    chk({tag, ".valid"}, 32'(lp_valid), 32'd0);
    chk({tag, ".marks"}, 32'({lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend}), 32'd0);
    chk({tag, ".aborted"}, 32'(pkt_aborted), 32'd0);
    chk({tag, ".tlp_ready"}, 32'(tlp_ready), 32'd0);
    chk({tag, ".dllp_ready"}, 32'(dllp_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string tag;
    int t_n, d_n;
    logic is_t;

    // ---------------- reset state ----------------
    lpreset = 1'b0;
    drive(1, 1, 1, 1, 32'h1111_1111, 1, 1, 1, 32'h2222_2222, 1);
    @(negedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    lpreset = 1'b1;

    // ---------------- vector table ----------------
    //   lu tv tf tl td              dv df dl dd              trdy | tr dr irdy data            tsrc first last ab
    add(1, 0, 0, 0, 0,              0, 0, 0, 0,              1,     0, 0, 0, 0,              0, 0, 0, 0);
    // 3-beat TLP alone
    add(1, 1, 1, 0, 32'hA000_0001, 0, 0, 0, 0,              1,     1, 0, 1, 32'hA000_0001, 1, 1, 0, 0);
    add(1, 1, 0, 0, 32'hA000_0002, 0, 0, 0, 0,              1,     1, 0, 1, 32'hA000_0002, 1, 0, 0, 0);
    add(1, 1, 0, 1, 32'hA000_0003, 0, 0, 0, 0,              1,     1, 0, 1, 32'hA000_0003, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0,              0, 0, 0, 0,              1,     0, 0, 0, 0,              0, 0, 0, 0);
    // 2-beat TLP, DLLP arrives on the last beat and waits for IDLE
    add(1, 1, 1, 0, 32'hB000_0001, 0, 0, 0, 0,              1,     1, 0, 1, 32'hB000_0001, 1, 1, 0, 0);
    add(1, 1, 0, 1, 32'hB000_0002, 1, 1, 1, 32'hD000_0001, 1,     1, 0, 1, 32'hB000_0002, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0,              1, 1, 1, 32'hD000_0001, 1,     0, 1, 1, 32'hD000_0001, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0,              0, 0, 0, 0,              1,     0, 0, 0, 0,              0, 0, 0, 0);
    // DLLP beat then a 5-cycle PHY stall with a TLP waiting
    add(1, 0, 0, 0, 0,              1, 1, 1, 32'hD000_0002, 1,     0, 1, 1, 32'hD000_0002, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++)
      add(1, 1, 1, 1, 32'hC000_0001, 0, 0, 0, 0,            0,     0, 0, 1, 32'hD000_0002, 0, 1, 1, 0);
    add(1, 1, 1, 1, 32'hC000_0001, 0, 0, 0, 0,              1,     1, 0, 1, 32'hC000_0001, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0,              0, 0, 0, 0,              1,     0, 0, 0, 0,              0, 0, 0, 0);
    // Both sources valid, single-beat packets: expected order D,D,D,D,T,D,D,D,D,T
    t_n = 1;
    d_n = 1;
    for (int k = 0; k < 10; k++) begin
      is_t = (k == 4) || (k == 9);
      add(1, 1, 1, 1, 32'h7000_0000 + t_n, 1, 1, 1, 32'hE000_0000 + d_n, 1,
          is_t, !is_t, 1, is_t ? 32'h7000_0000 + t_n : 32'hE000_0000 + d_n, is_t, 1, 1, 0);
      if (is_t) t_n++;
      else d_n++;
    end
    add(1, 0, 0, 0, 0,              0, 0, 0, 0,              1,     0, 0, 0, 0,              0, 0, 0, 0);
    // linkUp loss on beat 2 of a 4-beat TLP, then linkUp low in IDLE, then recovery
    add(1, 1, 1, 0, 32'hF000_0001, 0, 0, 0, 0,              1,     1, 0, 1, 32'hF000_0001, 1, 1, 0, 0);
    add(0, 1, 0, 0, 32'hF000_0002, 0, 0, 0, 0,              1,     0, 0, 0, 0,              0, 0, 0, 1);
    add(0, 1, 0, 0, 32'hF000_0002, 1, 1, 1, 32'hD000_0003, 1,     0, 0, 0, 0,              0, 0, 0, 0);
    add(1, 1, 1, 1, 32'hF100_0001, 0, 0, 0, 0,              1,     1, 0, 1, 32'hF100_0001, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0,              0, 0, 0, 0,              1,     0, 0, 0, 0,              0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      drive(tbl[i].lu, tbl[i].tv, tbl[i].tf, tbl[i].tl, tbl[i].td,
            tbl[i].dv, tbl[i].df, tbl[i].dl, tbl[i].dd, tbl[i].trdy);
      #1;
      tag = $sformatf("v%0d", i);
      chk({tag, ".tlp_ready"}, 32'(tlp_ready), 32'(tbl[i].e_tr));
      chk({tag, ".dllp_ready"}, 32'(dllp_ready), 32'(tbl[i].e_dr));
      @(posedge CLK);
      #1;
      chk({tag, ".aborted"}, 32'(pkt_aborted), 32'(tbl[i].e_ab));
      if (tbl[i].e_irdy)
        chk_beat(tag, tbl[i].e_data, tbl[i].e_tsrc, tbl[i].e_first, tbl[i].e_last);
      else
        chk({tag, ".irdy"}, 32'(lp_irdy), 32'd0);
    end

    // ---------------- reset mid-burst ----------------
    // Four DLLP grants with a TLP waiting saturate the starve counter.
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      drive(1, 1, 1, 1, 32'h5000_0001, 1, 1, 1, 32'h6000_0000 + k, 1);
      #1;
      chk($sformatf("rs_d%0d.dllp_ready", k), 32'(dllp_ready), 32'd1);
    end
    // Multi-beat DLLP alone: granted without touching the counter.
    @(negedge CLK);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 32'h6100_0001, 1);
    #1;
    chk("rs_burst1.dllp_ready", 32'(dllp_ready), 32'd1);
    // Second beat: grant locked to DLLP even with a TLP offered.
    @(negedge CLK);
    drive(1, 1, 1, 1, 32'h5000_0001, 1, 0, 0, 32'h6100_0002, 1);
    #1;
    chk("rs_lock.tlp_ready", 32'(tlp_ready), 32'd0);
    chk("rs_lock.dllp_ready", 32'(dllp_ready), 32'd1);
    chk_beat("rs_lock", 32'h6100_0001, 0, 1, 0);
    #1;
    lpreset = 1'b0;
    #1;
    chk_all_zero("rs_async");
    @(posedge CLK);
    #1;
    chk_all_zero("rs_held");
    @(negedge CLK);
    lpreset = 1'b1;
    // Counter cleared by reset: with both sources valid the DLLP wins first.
    drive(1, 1, 1, 1, 32'h5000_0002, 1, 1, 1, 32'h6200_0001, 1);
    #1;
    chk("rs_after.dllp_ready", 32'(dllp_ready), 32'd1);
    chk("rs_after.tlp_ready", 32'(tlp_ready), 32'd0);
    @(posedge CLK);
    #1;
    chk_beat("rs_after", 32'h6200_0001, 0, 1, 1);
    chk("rs_after.aborted", 32'(pkt_aborted), 32'd0);

    @(negedge CLK);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
